cordic_atanh_vectoring: RTL and testbench

Iterative hyperbolic CORDIC in vectoring mode. It is the inverse of the sinh/cosh rotation stage. Given an (x, y) pair in the synth's cosh/sinh fixed-point formats, it returns phase = atanh(y/x) in the phase format and the scaled hyperbolic magnitude. It sits in the envelope/drive path wherever a phase must be recovered from a sinh/cosh pair, and uses a valid/ready handshake on both sides.

---
 rtl/cordic_atanh_vectoring.sv | 161 ++++++++++++++++
 tb/tb_cordic_atanh_vectoring.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_atanh_vectoring.sv
// cordic_atanh_vectoring
//   Iterative hyperbolic CORDIC, vectoring mode. Drives Y toward zero over
//   16 micro-rotations and accumulates the angle, giving
//   phase = atanh(y/x) and mag = K_h*sqrt(x^2 - y^2) (gain uncorrected).
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  input handshake; ready only while idle
//   x, y            Q1.14 signed cosh/sinh pair, x > 0, |y| < x
//   out_valid/ready output handshake; result held until accepted
//   phase           Q3.13 signed atanh(y/x)
//   mag             Q1.14 signed scaled magnitude
//   err             input was outside the domain; phase/mag forced to 0
module cordic_atanh_vectoring (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] x,
    input  logic signed [15:0] y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] phase,
    output logic signed [15:0] mag,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic signed [19:0] x_q, x_d, y_q, y_d;     // Q4.16
    logic signed [17:0] z_q, z_d;               // Q3.15
    logic        [3:0]  k_q, k_d;
    logic               err_r_q, err_r_d;
    logic signed [15:0] phase_q, phase_d, mag_q, mag_d;
    logic               err_q, err_d;

    // Shift per iteration: 1..14 with 4 and 13 repeated for convergence.
    function automatic logic [3:0] shift_lut(input logic [3:0] k);
        if (k <= 4'd3)       return k + 4'd1;
        else if (k <= 4'd13) return k;
        else                 return k - 4'd1;
    endfunction

    // round(atanh(2^-s) * 2^15)
    function automatic logic [14:0] atanh_lut(input logic [3:0] s);
        case (s)
            4'd1:    return 15'd18000;
            4'd2:    return 15'd8369;
            4'd3:    return 15'd4118;
            4'd4:    return 15'd2051;
            4'd5:    return 15'd1024;
            4'd6:    return 15'd512;
            4'd7:    return 15'd256;
            4'd8:    return 15'd128;
            4'd9:    return 15'd64;
            4'd10:   return 15'd32;
            4'd11:   return 15'd16;
            4'd12:   return 15'd8;
            4'd13:   return 15'd4;
            4'd14:   return 15'd2;
            default: return 15'd0;
        endcase
    endfunction

    // One micro-rotation from the current registers.
    logic        [3:0]  sh;
    logic signed [19:0] xs, ys, x_n, y_n;
    logic signed [17:0] t, z_n;
    logic signed [16:0] zr;
    logic signed [15:0] phase_sat, mag_sat;
    logic signed [16:0] x17, ay17;

    assign sh  = shift_lut(k_q);
    assign xs  = x_q >>> sh;
    assign ys  = y_q >>> sh;
    assign t   = $signed({3'b000, atanh_lut(sh)});
    assign x_n = y_q[19] ? x_q + ys : x_q - ys;
    assign y_n = y_q[19] ? y_q + xs : y_q - xs;
    assign z_n = y_q[19] ? z_q - t  : z_q + t;

    // Round Z (Q3.15) to Q3.13 with half-up, then clamp to 16 bits.
    assign zr        = 17'(($signed({z_n[17], z_n}) + 19'sd2) >>> 2);
    assign phase_sat = (zr[16] != zr[15]) ? (zr[16] ? 16'sh8000 : 16'sh7FFF) : zr[15:0];
    assign mag_sat   = (x_n[19:17] != 3'b000) ? 16'sh7FFF : x_n[17:2];

    // 17-bit compare so y = -32768 yields |y| = 32768.
    assign x17  = $signed({x[15], x});
    assign ay17 = y[15] ? -$signed({y[15], y}) : $signed({y[15], y});

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        k_d     = k_q;
        err_r_d = err_r_q;
        phase_d = phase_q;
        mag_d   = mag_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = $signed({{2{x[15]}}, x, 2'b00});
                    y_d     = $signed({{2{y[15]}}, y, 2'b00});
                    z_d     = '0;
                    k_d     = '0;
                    err_r_d = (x17 <= 17'sd0) || (ay17 >= x17);
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d = x_n;
                y_d = y_n;
                z_d = z_n;
                k_d = k_q + 4'd1;
                if (k_q == 4'd15) begin
                    phase_d = err_r_q ? 16'sh0000 : phase_sat;
                    mag_d   = err_r_q ? 16'sh0000 : mag_sat;
                    err_d   = err_r_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            k_q     <= '0;
            err_r_q <= 1'b0;
            phase_q <= '0;
            mag_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            k_q     <= k_d;
            err_r_q <= err_r_d;
            phase_q <= phase_d;
            mag_q   <= mag_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign phase     = phase_q;
    assign mag       = mag_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cordic_atanh_vectoring.sv
// Bench for cordic_atanh_vectoring: directed cases, backpressure, reset
// abort, then random in-domain and out-of-domain inputs against a real-number
// model of atanh(y/x) and K_h*sqrt(x^2-y^2).
module tb_cordic_atanh_vectoring;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] phase;
    logic [15:0] mag;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    localparam real KH = 0.82816;

    cordic_atanh_vectoring dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .phase     (phase),
        .mag       (mag),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp, input int tol = 0);
        n_chk++;
        if (obs > exp + tol || obs < exp - tol) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Ideal result from the mathematical definition.
    task automatic model(input logic [15:0] xi, input logic [15:0] yi,
                         output int ph, output int mg, output bit e);
        int  xs, ys, ay;
        real xr, yr;
        xs = int'($signed(xi));
        ys = int'($signed(yi));
        ay = (ys < 0) ? -ys : ys;
        e  = (xs <= 0) || (ay >= xs);
        ph = 0;
        mg = 0;
        if (!e) begin
            xr = real'(xs) / 16384.0;
            yr = real'(ys) / 16384.0;
            ph = int'(0.5 * $ln((xr + yr) / (xr - yr)) * 8192.0);
            mg = int'(KH * $sqrt(xr * xr - yr * yr) * 16384.0);
        end
    endtask

    // Offer one input, check busy and 16-cycle latency, leave result pending.
    task automatic send(input logic [15:0] xi, input logic [15:0] yi);
        int n;
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        x = xi;
        y = yi;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("busy", int'(in_ready), 0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        chk("latency", lat, 16);
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("ov_drop", int'(out_valid), 0);
        chk("rdy_back", int'(in_ready), 1);
    endtask

    task automatic res(input string tag, input int ph, input int ptol,
                       input int mg, input int mtol, input bit e);
        chk({tag, "_phase"}, int'($signed(phase)), ph, ptol);
        chk({tag, "_mag"}, int'($signed(mag)), mg, mtol);
        chk({tag, "_err"}, int'(err), int'(e));
    endtask

    initial begin
        int ph, mg, lim, m;
        bit e;
        logic [15:0] xv, yv;

        // Reset state
        #3;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_mag", int'(mag), 0);
        chk("rst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed points
        send(16'h4000, 16'h0000); res("unit", 0, 2, 16'h3501, 2, 1'b0); take();
        send(16'h482B, 16'h215A); res("pos05", 16'h1000, 2, 16'h3501, 4, 1'b0); take();
        send(16'h482B, 16'hDEA6); res("neg05", -4096, 2, 16'h3501, 4, 1'b0); take();
        send(16'h2000, 16'h2000); res("eq", 0, 0, 0, 0, 1'b1); take();
        send(16'h0000, 16'h0000); res("zero", 0, 0, 0, 0, 1'b1); take();
        send(16'h7FFF, 16'h8000); res("ymin", 0, 0, 0, 0, 1'b1); take();

        // Backpressure: result held, new input ignored
        send(16'h4000, 16'h0000);
        @(negedge clk);
        in_valid = 1'b1;
        x = 16'h482B;
        y = 16'h215A;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_ready", int'(in_ready), 0);
            res("bp", 0, 2, 16'h3501, 2, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        take();
        @(posedge clk);
        #1;
        chk("bp_no_capture", int'(in_ready), 1);

        // Reset in the middle of RUN
        @(negedge clk);
        in_valid = 1'b1;
        x = 16'h4000;
        y = 16'h0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", int'(in_ready), 1);
        chk("abort_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_out", int'(out_valid), 0);
        send(16'h482B, 16'h215A); res("post_rst", 16'h1000, 2, 16'h3501, 4, 1'b0); take();

        // Random in-domain inputs (|atanh| < ~0.98)
        for (int i = 0; i < 30; i++) begin
            xv  = 16'($urandom_range(16'h2000, 16'h7FFF));
            lim = (int'(xv) * 3) / 4;
            yv  = 16'(int'($urandom_range(0, 2 * lim)) - lim);
            model(xv, yv, ph, mg, e);
            send(xv, yv);
            res("rnd", ph, 3, mg, 5, e);
            take();
        end

        // Random out-of-domain inputs
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                xv = 16'($urandom_range(32768, 65536));
                yv = 16'($urandom);
            end else begin
                xv = 16'($urandom_range(1, 32767));
                m  = int'($urandom_range(int'(xv), 32768));
                yv = ($urandom_range(0, 1) == 1) ? 16'(-m) : 16'(m);
            end
            model(xv, yv, ph, mg, e);
            send(xv, yv);
            res("rnd_err", ph, 0, mg, 0, e);
            take();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
